// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter with round-robin grant and a per-transfer
// acknowledge timeout that aborts a stalled owner with a one-cycle error pulse.
module wb_arb2 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   // master 0
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   // master 1
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   // shared slave
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   // grant
   output logic [1:0]  gnt_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic        r_owner;
   logic        r_last_owner;
   logic [7:0]  r_wait_cnt;

   logic        w_busy;
   logic        w_granted;
   logic        w_own_cyc;
   logic        w_own_stb;
   logic        w_own_we;
   logic [31:0] w_own_adr;
   logic [3:0]  w_own_sel;
   logic [31:0] w_own_dat;
   logic        w_stalled;
   logic        w_timeout;
   logic        w_any_req;
   logic        w_pick_m1;

   assign w_busy    = (r_state == ST_BUSY);
   assign w_granted = (r_state == ST_BUSY) || (r_state == ST_ABORT);

   assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
   assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
   assign w_own_we  = r_owner ? m1_we_i  : m0_we_i;
   assign w_own_adr = r_owner ? m1_adr_i : m0_adr_i;
   assign w_own_sel = r_owner ? m1_sel_i : m0_sel_i;
   assign w_own_dat = r_owner ? m1_dat_i : m0_dat_i;

   // An acknowledge in the threshold cycle completes the transfer, so ack wins.
   assign w_stalled = w_busy && w_own_stb && !s_ack_i;
   assign w_timeout = w_stalled && (r_wait_cnt == WAIT_LAST);

   // Round robin: on contention the master that did not own the bus last wins.
   assign w_any_req = m0_cyc_i || m1_cyc_i;
   assign w_pick_m1 = m1_cyc_i && (!m0_cyc_i || !r_last_owner);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_pick_m1;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_own_cyc) begin
                  r_state      <= ST_IDLE;
                  r_last_owner <= r_owner;
               end else if (w_timeout) begin
                  r_state <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               if (!w_own_cyc) begin
                  r_state      <= ST_IDLE;
                  r_last_owner <= r_owner;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Counts consecutive strobed, unacknowledged BUSY cycles; anything else clears it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wait_cnt <= 8'd0;
      end else if (w_stalled) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
         r_wait_cnt <= 8'd0;
      end
   end

   // NOTE: every output gets a default before the case split, so no path
   // through this block leaves a value unassigned and no latch is inferred.
   always_comb begin
      gnt_o    = 2'b00;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = 32'd0;
      s_sel_o  = 4'd0;
      s_dat_o  = 32'd0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_dat_o = 32'd0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_dat_o = 32'd0;

      if (w_granted) begin
         gnt_o = r_owner ? 2'b10 : 2'b01;
      end

      if (w_busy) begin
         s_cyc_o = w_own_cyc;
         s_stb_o = w_own_stb;
         s_we_o  = w_own_we;
         s_adr_o = w_own_adr;
         s_sel_o = w_own_sel;
         s_dat_o = w_own_dat;
         if (r_owner) begin
            m1_ack_o = s_ack_i;
            m1_err_o = w_timeout;
            m1_dat_o = s_dat_i;
         end else begin
            m0_ack_o = s_ack_i;
            m0_err_o = w_timeout;
            m0_dat_o = s_dat_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_wb_arb2;

   localparam int TO_MAIN = 16;
   localparam int TO_FAST = 4;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic [3:0]  m0_sel_i;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] s_dat_i;
   logic        s_ack_i;

   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [1:0]  gnt_o;

   logic [31:0] t4_m0_dat_o, t4_m1_dat_o, t4_s_adr_o, t4_s_dat_o;
   logic        t4_m0_ack_o, t4_m0_err_o, t4_m1_ack_o, t4_m1_err_o;
   logic        t4_s_cyc_o, t4_s_stb_o, t4_s_we_o;
   logic [3:0]  t4_s_sel_o;
   logic [1:0]  t4_gnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   wb_arb2 #(.TIMEOUT(TO_MAIN)) u_dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
   );

   // Short-timeout instance sharing all inputs, used for the threshold boundary.
   wb_arb2 #(.TIMEOUT(TO_FAST)) u_dut4 (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(t4_m0_dat_o), .m0_ack_o(t4_m0_ack_o), .m0_err_o(t4_m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(t4_m1_dat_o), .m1_ack_o(t4_m1_ack_o), .m1_err_o(t4_m1_err_o),
      .s_cyc_o(t4_s_cyc_o), .s_stb_o(t4_s_stb_o), .s_we_o(t4_s_we_o),
      .s_adr_o(t4_s_adr_o), .s_sel_o(t4_s_sel_o), .s_dat_o(t4_s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(t4_gnt_o)
   );

   initial forever #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [140:0] act, input logic [140:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [140:0] pack_main();
      return {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
              m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
   endfunction

   task automatic set_m0(input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
      m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_sel_i = sl; m0_dat_i = d;
   endtask

   task automatic set_m1(input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
      m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_sel_i = sl; m1_dat_i = d;
   endtask

   task automatic all_idle();
      set_m0(0, 0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0, 0);
      s_ack_i = 0;
      s_dat_i = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   int mdl_owner;   // -1 when nobody holds the bus
   bit mdl_abort;
   int mdl_last;
   int mdl_wait;

   function automatic logic [140:0] mdl_expect();
      logic        cyc [2];
      logic        stb [2];
      logic        we  [2];
      logic [31:0] adr [2];
      logic [3:0]  sel [2];
      logic [31:0] wd  [2];
      logic        ack [2];
      logic        err [2];
      logic [31:0] rd  [2];
      logic [1:0]  gnt;
      logic        sc, ss, sw;
      logic [31:0] sa, sd;
      logic [3:0]  sl;
      int          o;
      cyc[0] = m0_cyc_i; stb[0] = m0_stb_i; we[0] = m0_we_i;
      adr[0] = m0_adr_i; sel[0] = m0_sel_i; wd[0] = m0_dat_i;
      cyc[1] = m1_cyc_i; stb[1] = m1_stb_i; we[1] = m1_we_i;
      adr[1] = m1_adr_i; sel[1] = m1_sel_i; wd[1] = m1_dat_i;
      ack[0] = 0; ack[1] = 0; err[0] = 0; err[1] = 0; rd[0] = 0; rd[1] = 0;
      gnt = 0; sc = 0; ss = 0; sw = 0; sa = 0; sd = 0; sl = 0;
      o = mdl_owner;
      if (o >= 0) begin
         gnt = (o == 0) ? 2'b01 : 2'b10;
         if (!mdl_abort) begin
            sc = cyc[o]; ss = stb[o]; sw = we[o]; sa = adr[o]; sl = sel[o]; sd = wd[o];
            ack[o] = s_ack_i;
            rd[o]  = s_dat_i;
            err[o] = stb[o] && !s_ack_i && (mdl_wait == TO_MAIN - 1);
         end
      end
      return {gnt, sc, ss, sw, sa, sl, sd, ack[0], err[0], rd[0], ack[1], err[1], rd[1]};
   endfunction

   task automatic mdl_step();
      logic cyc [2];
      logic stb [2];
      int   o;
      cyc[0] = m0_cyc_i; cyc[1] = m1_cyc_i;
      stb[0] = m0_stb_i; stb[1] = m1_stb_i;
      o = mdl_owner;
      if (o < 0) begin
         if (cyc[0] && cyc[1]) mdl_owner = 1 - mdl_last;
         else if (cyc[0])      mdl_owner = 0;
         else if (cyc[1])      mdl_owner = 1;
         mdl_wait  = 0;
         mdl_abort = 0;
      end else if (!cyc[o]) begin
         mdl_last  = o;
         mdl_owner = -1;
         mdl_abort = 0;
         mdl_wait  = 0;
      end else if (!mdl_abort) begin
         if (stb[o] && !s_ack_i) begin
            if (mdl_wait == TO_MAIN - 1) begin
               mdl_abort = 1;
               mdl_wait  = 0;
            end else begin
               mdl_wait = mdl_wait + 1;
            end
         end else begin
            mdl_wait = 0;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        m0_cyc, m0_stb;
      logic [31:0] m0_adr, m0_dat;
      logic        m1_cyc;
      logic        s_ack;
      logic [31:0] s_dat;
      logic [1:0]  e_gnt;
      logic        e_stb;
      logic [31:0] e_adr, e_sdat;
      logic        e_ack0, e_ack1;
      logic [31:0] e_dat0, e_dat1;
   } vec_t;

   vec_t tbl [16];

   logic ack_en;
   logic hold;

   initial begin
      // m0 single write (0x400/0xA5, acked after two wait cycles), then m0 holding
      // the bus over three acked transfers while m1 waits, then m1's turn.
      tbl[0]  = '{0,0, 32'h0,   32'h0,  0, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[1]  = '{1,1, 32'h400, 32'hA5, 0, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[2]  = '{1,1, 32'h400, 32'hA5, 0, 0, 32'h0,    2'b01, 1, 32'h400, 32'hA5, 0,0, 32'h0,    32'h0};
      tbl[3]  = '{1,1, 32'h400, 32'hA5, 0, 0, 32'hDEAD, 2'b01, 1, 32'h400, 32'hA5, 0,0, 32'hDEAD, 32'h0};
      tbl[4]  = '{1,1, 32'h400, 32'hA5, 0, 1, 32'h0,    2'b01, 1, 32'h400, 32'hA5, 1,0, 32'h0,    32'h0};
      tbl[5]  = '{0,0, 32'h0,   32'h0,  0, 0, 32'h0,    2'b01, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[6]  = '{0,0, 32'h0,   32'h0,  0, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[7]  = '{1,1, 32'h10,  32'h1,  0, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[8]  = '{1,1, 32'h10,  32'h1,  1, 1, 32'h11,   2'b01, 1, 32'h10,  32'h1,  1,0, 32'h11,   32'h0};
      tbl[9]  = '{1,1, 32'h14,  32'h2,  1, 1, 32'h22,   2'b01, 1, 32'h14,  32'h2,  1,0, 32'h22,   32'h0};
      tbl[10] = '{1,1, 32'h18,  32'h3,  1, 1, 32'h33,   2'b01, 1, 32'h18,  32'h3,  1,0, 32'h33,   32'h0};
      tbl[11] = '{0,0, 32'h0,   32'h0,  1, 0, 32'h0,    2'b01, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[12] = '{0,0, 32'h0,   32'h0,  1, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[13] = '{0,0, 32'h0,   32'h0,  1, 1, 32'h77,   2'b10, 1, 32'h800, 32'h5A, 0,1, 32'h0,    32'h77};
      tbl[14] = '{0,0, 32'h0,   32'h0,  0, 0, 32'h0,    2'b10, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};
      tbl[15] = '{0,0, 32'h0,   32'h0,  0, 0, 32'h0,    2'b00, 0, 32'h0,   32'h0,  0,0, 32'h0,    32'h0};

      // ---- reset: outputs must be 0 even with active inputs ----
      rst_n_i = 1'b0;
      set_m0(1, 1, 1, 32'h1234, 4'hF, 32'h55);
      set_m1(1, 1, 0, 32'h5678, 4'h3, 32'h66);
      s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
      #2;
      check("reset_outputs", pack_main(), '0);
      next_cycle();
      next_cycle();
      check("reset_outputs_held", pack_main(), '0);
      check("reset_outputs_t4", {t4_gnt_o, t4_s_cyc_o, t4_s_stb_o, t4_m0_ack_o, t4_m1_ack_o}, '0);
      all_idle();
      rst_n_i = 1'b1;

      // ---- vector table ----
      for (int i = 0; i < 16; i++) begin
         set_m0(tbl[i].m0_cyc, tbl[i].m0_stb, tbl[i].m0_cyc, tbl[i].m0_adr, tbl[i].m0_cyc ? 4'hF : 4'h0, tbl[i].m0_dat);
         set_m1(tbl[i].m1_cyc, tbl[i].m1_cyc, 0, tbl[i].m1_cyc ? 32'h800 : 32'h0, tbl[i].m1_cyc ? 4'h3 : 4'h0,
                tbl[i].m1_cyc ? 32'h5A : 32'h0);
         s_ack_i = tbl[i].s_ack;
         s_dat_i = tbl[i].s_dat;
         @(negedge clk_i);
         check($sformatf("vec%0d", i),
               {gnt_o, s_stb_o, s_adr_o, s_dat_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o},
               {tbl[i].e_gnt, tbl[i].e_stb, tbl[i].e_adr, tbl[i].e_sdat, tbl[i].e_ack0, 1'b0,
                tbl[i].e_ack1, 1'b0, tbl[i].e_dat0, tbl[i].e_dat1});
         next_cycle();
      end

      // ---- round robin: both request together four times ----
      for (int k = 0; k < 4; k++) begin
         set_m0(1, 1, 1, 32'h100 + k, 4'hF, k);
         set_m1(1, 1, 0, 32'h200 + k, 4'hF, k);
         s_ack_i = 0;
         @(negedge clk_i);
         check($sformatf("rr_idle%0d", k), gnt_o, 2'b00);
         next_cycle();
         s_ack_i = 1;
         @(negedge clk_i);
         check($sformatf("rr_grant%0d", k), {gnt_o, m0_ack_o, m1_ack_o},
               (k % 2 == 0) ? 4'b01_10 : 4'b10_01);
         next_cycle();
         s_ack_i = 0;
         all_idle();
         @(negedge clk_i);
         check($sformatf("rr_release%0d", k), gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
         next_cycle();
      end

      // ---- m1 read never acked: error in 16th strobed cycle ----
      set_m1(1, 1, 0, 32'h900, 4'hF, 0);
      @(negedge clk_i);
      check("to_idle", gnt_o, 2'b00);
      next_cycle();
      for (int n = 1; n <= TO_MAIN; n++) begin
         @(negedge clk_i);
         check($sformatf("to_cycle%0d", n), {m1_err_o, m0_err_o, s_stb_o, gnt_o},
               {(n == TO_MAIN), 1'b0, 1'b1, 2'b10});
         next_cycle();
      end
      s_ack_i = 1;
      @(negedge clk_i);
      check("to_abort", {m1_err_o, m1_ack_o, s_stb_o, s_cyc_o, gnt_o}, {4'b0000, 2'b10});
      next_cycle();
      s_ack_i = 0;
      @(negedge clk_i);
      check("to_abort_hold", {m1_err_o, s_stb_o, gnt_o}, {2'b00, 2'b10});
      next_cycle();
      all_idle();
      @(negedge clk_i);
      check("to_drop", gnt_o, 2'b10);
      next_cycle();
      @(negedge clk_i);
      check("to_back_idle", gnt_o, 2'b00);

      // ---- TIMEOUT=4: ack in threshold cycle wins, then a real timeout ----
      set_m0(1, 1, 0, 32'h40, 4'hF, 0);
      next_cycle();
      for (int n = 1; n <= 4; n++) begin
         s_ack_i = (n == 4);
         @(negedge clk_i);
         check($sformatf("t4_ack_cycle%0d", n), {t4_m0_ack_o, t4_m0_err_o, t4_s_stb_o, t4_gnt_o},
               {(n == 4), 1'b0, 1'b1, 2'b01});
         next_cycle();
      end
      s_ack_i = 0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk_i);
         check($sformatf("t4_restart%0d", n), {t4_m0_err_o, t4_s_stb_o, t4_gnt_o}, {(n == 4), 1'b1, 2'b01});
         next_cycle();
      end
      @(negedge clk_i);
      check("t4_aborted", {t4_s_stb_o, t4_gnt_o, s_stb_o, m0_err_o}, {1'b0, 2'b01, 1'b1, 1'b0});
      all_idle();
      next_cycle();
      next_cycle();

      // ---- async reset mid-transfer for m1, then contention goes to m0 ----
      set_m1(1, 1, 0, 32'hA00, 4'hF, 32'h9);
      next_cycle();
      @(negedge clk_i);
      check("rst_pre", gnt_o, 2'b10);
      #2;
      s_ack_i = 1;
      rst_n_i = 0;
      #1;
      check("rst_async", pack_main(), '0);
      next_cycle();
      check("rst_async_held", pack_main(), '0);
      @(negedge clk_i);
      rst_n_i = 1;
      s_ack_i = 0;
      set_m0(1, 1, 1, 32'hB00, 4'hF, 32'h7);
      next_cycle();
      @(negedge clk_i);
      check("rst_then_m0", {gnt_o, m1_ack_o}, 3'b010);
      all_idle();
      next_cycle();
      next_cycle();

      // ---- randomized traffic against the reference model ----
      rst_n_i = 0;
      next_cycle();
      rst_n_i = 1;
      mdl_owner = -1; mdl_abort = 0; mdl_last = 1; mdl_wait = 0;
      ack_en = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 48 == 0) ack_en = ($urandom_range(0, 1) == 1);
         hold = m0_cyc_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
         set_m0(hold, hold && ($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 4'($urandom), $urandom);
         hold = m1_cyc_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
         set_m1(hold, hold && ($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 4'($urandom), $urandom);
         s_ack_i = ack_en && ($urandom_range(0, 2) == 0);
         s_dat_i = $urandom;
         @(negedge clk_i);
         check($sformatf("rand%0d", c), pack_main(), mdl_expect());
         mdl_step();
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
